// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - multi-cycle load/store unit with req/ack data bus, byte lanes and bus timeout
// Optional misaligned-access trap: define LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic        bus_err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic [7:0]  tmo_cnt;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic        illegal;
  logic        misaligned;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  always_comb begin
    case (funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b100, 3'b101:         illegal = lsu_we;
      default:                illegal = 1'b0;
    endcase
  end

  // Sub-word sizes ignore the low address bits below their own alignment.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << addr[1:0];
        wdata_n = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << {addr[1], 1'b0};
        wdata_n = {2{wdata[15:0]}};
      end
      default: begin
        be_n    = 4'b1111;
        wdata_n = wdata;
      end
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    byte_sel = mem_rdata[{lane_q, 3'b000} +: 8];
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_ext = {24'b0, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_ext = {16'b0, half_sel};
      default: load_ext = mem_rdata;
    endcase
  end

  assign stall = ~reset & ((lsu_valid & (state == IDLE)) | (state == BUSY));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      f3_q      <= '0;
      lane_q    <= '0;
      done      <= 1'b0;
      rdata     <= '0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            mem_we    <= lsu_we;
            f3_q      <= funct3;
            lane_q    <= addr[1:0];
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_n;
            mem_wdata <= wdata_n;
            rdata     <= '0;
            bus_err   <= 1'b0;
            tmo_cnt   <= '0;
            if (illegal) begin
              bus_err <= 1'b1;
              done    <= 1'b1;
              state   <= DONE;
            end else if (misaligned) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              mem_req <= 1'b1;
              state   <= BUSY;
            end
          end
        end
        BUSY: begin
          // An ack in the final timeout cycle still completes the access.
          if (mem_ack) begin
            if (!mem_we) rdata <= load_ext;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else if (tmo_cnt == TMO_LAST) begin
            bus_err <= 1'b1;
            rdata   <= '0;
            mem_req <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      misalign_q <= 1'b0;
    else if ((state == IDLE) && lsu_valid)
      misalign_q <= misaligned & ~illegal;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule
